// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, fetch reset/bubble encodings and fetch state encoding.
package rv32i_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP_REG = 7'b0110011;

   // addi x0,x0,0 is the architectural NOP used for every pipeline bubble
   localparam logic [31:0] NOP_INST           = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } fetchState_e;

   function automatic logic isWordAligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: instruction-memory port, hazard/redirect controls and IF/ID outputs.
interface fetch_stage_if;

   logic [31:0] o_imem_raddr;
   logic [31:0] i_imem_rdata;
   logic        i_stall;
   logic        i_redirect_en;
   logic [31:0] i_redirect_target;
   logic        i_halt;
   logic [31:0] o_if_inst;
   logic [31:0] o_if_pc;
   logic [31:0] o_if_pc_plus4;
   logic        o_if_valid;
   logic        o_halted;
   logic        o_trap_misaligned;

   modport master (
      output o_imem_raddr,
      input  i_imem_rdata,
      input  i_stall,
      input  i_redirect_en,
      input  i_redirect_target,
      input  i_halt,
      output o_if_inst,
      output o_if_pc,
      output o_if_pc_plus4,
      output o_if_valid,
      output o_halted,
      output o_trap_misaligned
   );

   modport slave (
      input  o_imem_raddr,
      output i_imem_rdata,
      output i_stall,
      output i_redirect_en,
      output i_redirect_target,
      output i_halt,
      input  o_if_inst,
      input  o_if_pc,
      input  o_if_pc_plus4,
      input  o_if_valid,
      input  o_halted,
      input  o_trap_misaligned
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble outranks hold so a flush always clears a stalled entry.
module if_id_reg #(
   parameter logic [31:0] BUBBLE_INST = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hold_i,
   input  logic        bubble_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pcPlus4_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic [31:0] pcPlus4_o,
   output logic        valid_o
);

   logic [31:0] instQ;
   logic [31:0] pcQ;
   logic [31:0] pcPlus4Q;
   logic        validQ;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instQ    <= BUBBLE_INST;
         pcQ      <= 32'd0;
         pcPlus4Q <= 32'd0;
         validQ   <= 1'b0;
      end else if (bubble_i) begin
         // bubble keeps the stale PC fields; only the instruction and valid matter downstream
         instQ  <= BUBBLE_INST;
         validQ <= 1'b0;
      end else if (!hold_i) begin
         instQ    <= inst_i;
         pcQ      <= pc_i;
         pcPlus4Q <= pcPlus4_i;
         validQ   <= 1'b1;
      end
   end

   assign inst_o    = instQ;
   assign pc_o      = pcQ;
   assign pcPlus4_o = pcPlus4Q;
   assign valid_o   = validQ;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, sequences BOOT/RUN/HALT and feeds the IF/ID register.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
   parameter logic [31:0] NOP_INST   = rv32i_pkg::NOP_INST
) (
   input  logic          i_clk,
   input  logic          i_rst,
   fetch_stage_if.master bus
);

   fetchState_e stateQ, stateD;
   logic [31:0] pcQ, pcD;
   logic        trapQ, trapD;
   logic        ifHold;
   logic        ifBubble;
   logic [31:0] pcPlus4;

   assign pcPlus4 = pcQ + 32'd4;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stateQ <= S_BOOT;
         pcQ    <= RESET_ADDR;
         trapQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         pcQ    <= pcD;
         trapQ  <= trapD;
      end
   end

   // Halt outranks redirect, redirect outranks stall; HALT is left only through reset.
   always_comb begin
      stateD   = stateQ;
      pcD      = pcQ;
      trapD    = trapQ;
      ifHold   = 1'b0;
      ifBubble = 1'b0;
      case (stateQ)
         S_BOOT: begin
            ifBubble = 1'b1;
            stateD   = bus.i_halt ? S_HALT : S_RUN;
         end
         S_RUN: begin
            if (bus.i_halt) begin
               stateD   = S_HALT;
               ifBubble = 1'b1;
            end else if (bus.i_redirect_en && !isWordAligned(bus.i_redirect_target)) begin
               trapD    = 1'b1;
               stateD   = S_HALT;
               ifBubble = 1'b1;
            end else if (bus.i_redirect_en) begin
               pcD      = bus.i_redirect_target;
               ifBubble = 1'b1;
            end else if (bus.i_stall) begin
               ifHold = 1'b1;
            end else begin
               pcD = pcPlus4;
            end
         end
         S_HALT: begin
            ifBubble = 1'b1;
         end
         default: begin
            stateD   = S_BOOT;
            ifBubble = 1'b1;
         end
      endcase
   end

   if_id_reg #(
      .BUBBLE_INST (NOP_INST)
   ) u_if_id_reg (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .hold_i    (ifHold),
      .bubble_i  (ifBubble),
      .inst_i    (bus.i_imem_rdata),
      .pc_i      (pcQ),
      .pcPlus4_i (pcPlus4),
      .inst_o    (bus.o_if_inst),
      .pc_o      (bus.o_if_pc),
      .pcPlus4_o (bus.o_if_pc_plus4),
      .valid_o   (bus.o_if_valid)
   );

   assign bus.o_imem_raddr      = pcQ;
   assign bus.o_halted          = (stateQ == S_HALT);
   assign bus.o_trap_misaligned = trapQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps push expected IF/ID entries, a negedge monitor pops them.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] MEM_TAG = 32'hDEAD_0000;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pcPlus4;
   } ifEntry_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic monitorOn;
   ifEntry_t expQ[$];

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_ADDR (32'h0000_0000),
      .NOP_INST   (NOP)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   // Instruction memory: each word is its address tagged, so inst and pc are distinguishable
   assign bus.i_imem_rdata = bus.o_imem_raddr ^ MEM_TAG;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ MEM_TAG;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock of stimulus; the expected IF/ID entry is queued right after the edge that loads it
   task automatic applyStimulus(input logic rstIn, input logic stall, input logic redir,
                                input logic [31:0] target, input logic halt,
                                input logic expValid, input logic [31:0] expPc);
      ifEntry_t e;
      rst                   = rstIn;
      bus.i_stall           = stall;
      bus.i_redirect_en     = redir;
      bus.i_redirect_target = target;
      bus.i_halt            = halt;
      @(posedge clk);
      if (expValid) begin
         e.inst    = memWord(expPc);
         e.pc      = expPc;
         e.pcPlus4 = expPc + 32'd4;
         expQ.push_back(e);
      end
      #1;
   endtask

   task automatic runCycle(input logic expValid, input logic [31:0] expPc);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, expValid, expPc);
   endtask

   always @(negedge clk) begin
      if (monitorOn) begin
         if (bus.o_if_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid actual pc=%h required no valid entry", bus.o_if_pc);
            end else begin
               ifEntry_t e;
               e = expQ.pop_front();
               checkOutput("if_inst", bus.o_if_inst, e.inst);
               checkOutput("if_pc", bus.o_if_pc, e.pc);
               checkOutput("if_pc_plus4", bus.o_if_pc_plus4, e.pcPlus4);
            end
         end else begin
            checkOutput("bubble_inst", bus.o_if_inst, NOP);
         end
      end
   end

   initial begin
      checks    = 0;
      errors    = 0;
      monitorOn = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("rst_raddr", bus.o_imem_raddr, 32'h0);
      checkOutput("rst_valid", {31'd0, bus.o_if_valid}, 32'd0);
      checkOutput("rst_halted", {31'd0, bus.o_halted}, 32'd0);
      checkOutput("rst_trap", {31'd0, bus.o_trap_misaligned}, 32'd0);
      checkOutput("rst_pc", bus.o_if_pc, 32'h0);
      checkOutput("rst_pc_plus4", bus.o_if_pc_plus4, 32'h0);
      monitorOn = 1'b1;

      // BOOT cycle: PC presented, IF/ID stays a bubble
      runCycle(1'b0, 32'h0);
      checkOutput("boot_raddr", bus.o_imem_raddr, 32'h0);
      checkOutput("boot_valid", {31'd0, bus.o_if_valid}, 32'd0);

      runCycle(1'b1, 32'h0);
      checkOutput("run_raddr4", bus.o_imem_raddr, 32'h4);
      checkOutput("run_valid", {31'd0, bus.o_if_valid}, 32'd1);
      runCycle(1'b1, 32'h4);
      checkOutput("run_raddr8", bus.o_imem_raddr, 32'h8);

      // Stall two cycles at PC=8: IF/ID keeps the pc=4 entry
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
      checkOutput("stall1_raddr", bus.o_imem_raddr, 32'h8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4);
      checkOutput("stall2_raddr", bus.o_imem_raddr, 32'h8);
      runCycle(1'b1, 32'h8);
      checkOutput("resume_raddr", bus.o_imem_raddr, 32'hC);
      runCycle(1'b1, 32'hC);
      checkOutput("resume_raddr2", bus.o_imem_raddr, 32'h10);

      // Redirect to 0x40 from PC=0x10
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
      checkOutput("redir_raddr", bus.o_imem_raddr, 32'h40);
      checkOutput("redir_valid", {31'd0, bus.o_if_valid}, 32'd0);
      runCycle(1'b1, 32'h40);
      checkOutput("redir_next_raddr", bus.o_imem_raddr, 32'h44);

      // Redirect together with stall: redirect wins
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
      checkOutput("redir_stall_raddr", bus.o_imem_raddr, 32'h80);
      checkOutput("redir_stall_valid", {31'd0, bus.o_if_valid}, 32'd0);
      runCycle(1'b1, 32'h80);
      checkOutput("redir_stall_next", bus.o_imem_raddr, 32'h84);

      // Misaligned redirect traps and halts; later redirects are ignored
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h0);
      checkOutput("mis_trap", {31'd0, bus.o_trap_misaligned}, 32'd1);
      checkOutput("mis_halted", {31'd0, bus.o_halted}, 32'd1);
      checkOutput("mis_raddr", bus.o_imem_raddr, 32'h84);
      checkOutput("mis_valid", {31'd0, bus.o_if_valid}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
      checkOutput("mis_ignore_raddr", bus.o_imem_raddr, 32'h84);
      runCycle(1'b0, 32'h0);
      checkOutput("mis_hold_halted", {31'd0, bus.o_halted}, 32'd1);
      checkOutput("mis_hold_trap", {31'd0, bus.o_trap_misaligned}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("mis_rst_raddr", bus.o_imem_raddr, 32'h0);
      checkOutput("mis_rst_trap", {31'd0, bus.o_trap_misaligned}, 32'd0);
      checkOutput("mis_rst_halted", {31'd0, bus.o_halted}, 32'd0);
      runCycle(1'b0, 32'h0);

      // Halt at PC=0x20
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
      checkOutput("pre_halt_raddr", bus.o_imem_raddr, 32'h20);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_halted", {31'd0, bus.o_halted}, 32'd1);
      checkOutput("halt_raddr", bus.o_imem_raddr, 32'h20);
      checkOutput("halt_trap", {31'd0, bus.o_trap_misaligned}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         runCycle(1'b0, 32'h0);
         checkOutput("halt_stay_raddr", bus.o_imem_raddr, 32'h20);
         checkOutput("halt_stay_valid", {31'd0, bus.o_if_valid}, 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("halt_rst_raddr", bus.o_imem_raddr, 32'h0);
      checkOutput("halt_rst_halted", {31'd0, bus.o_halted}, 32'd0);
      runCycle(1'b0, 32'h0);
      runCycle(1'b1, 32'h0);
      checkOutput("reboot_raddr", bus.o_imem_raddr, 32'h4);

      // PC wrap at the top of the address space
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
      checkOutput("wrap_pre_raddr", bus.o_imem_raddr, 32'hFFFF_FFFC);
      runCycle(1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap_raddr", bus.o_imem_raddr, 32'h0);
      runCycle(1'b1, 32'h0);
      checkOutput("wrap_next_raddr", bus.o_imem_raddr, 32'h4);

      // Halt requested during BOOT goes straight to HALT
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("boot_halt_halted", {31'd0, bus.o_halted}, 32'd1);
      runCycle(1'b0, 32'h0);
      checkOutput("boot_halt_raddr", bus.o_imem_raddr, 32'h0);

      @(negedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline. Owns the PC, drives the instruction-memory read address and registers the returned word into the IF/ID register.
- Feeds the decode stage, whose control unit consumes inst[6:0].
- Handles stall, flush, redirect (branch/jump) and halt, and inserts the canonical NOP as a bubble.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- o_imem_raddr  out  32  instruction-memory read address; always equals the PC register.
- i_imem_rdata  in  32  instruction word; combinational read of o_imem_raddr, valid in the same cycle.
- i_stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- i_redirect_en  in  1  taken branch or jump resolved downstream.
- i_redirect_target  in  32  new PC when i_redirect_en=1.
- i_halt  in  1  stop fetching (ebreak/ecall/illegal opcode seen downstream).
- o_if_inst  out  32  IF/ID instruction.
- o_if_pc  out  32  IF/ID PC of o_if_inst.
- o_if_pc_plus4  out  32  o_if_pc + 4, registered.
- o_if_valid  out  1  IF/ID holds a real instruction.
- o_halted  out  1  stage is in HALT.
- o_trap_misaligned  out  1  sticky; a redirect target had [1:0] != 0.

Behaviour:
- Reset (synchronous, any state, mid-operation included):
  - pc <= RESET_ADDR; o_if_inst <= NOP_INST; o_if_pc <= 0; o_if_pc_plus4 <= 0.
  - o_if_valid <= 0; o_halted <= 0; o_trap_misaligned <= 0; state <= S_BOOT.
- States:
  - S_BOOT: one cycle. PC presented and IF/ID stays a bubble. Next state S_RUN unconditionally, unless i_halt=1, which goes to S_HALT.
  - S_RUN: normal fetch.
  - S_HALT: PC frozen; IF/ID forced to a bubble (NOP, valid 0); o_halted=1. All inputs ignored; exit only via reset.
- S_RUN per-cycle priority, highest first:
  1. i_halt: goes to S_HALT; IF/ID becomes a bubble; PC unchanged.
  2. i_redirect_en with i_redirect_target[1:0] != 0: o_trap_misaligned <= 1; goes to S_HALT; IF/ID becomes a bubble.
  3. i_redirect_en with an aligned target: pc <= target; IF/ID becomes a bubble (flushes the wrong-path fetch). Overrides i_stall.
  4. i_stall: pc and IF/ID hold their values exactly.
  5. Otherwise: pc <= pc + 4; IF/ID <= {i_imem_rdata, pc, pc+4}; o_if_valid <= 1.
- Arithmetic: PC addition is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Latency: the word at address A appears on o_if_inst one cycle after o_imem_raddr == A, absent stall or redirect. Throughput is 1 instr/cycle.
- No combinational path exists from any input to o_if_* or o_halted; o_imem_raddr is a register output.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP_REG);
  - NOP_INST and the default RESET_ADDR;
  - fetch state encoding S_BOOT/S_RUN/S_HALT.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with hold (stall) and bubble (flush) controls. PC logic and the FSM stay in fetch_stage.

Test Plan:
- Reset then free run, memory word = address: o_imem_raddr sequence 0,4,8. o_if_valid rises on the cycle after S_BOOT's successor edge. o_if_inst/o_if_pc follow 0/0, 4/4, with o_if_pc_plus4 = pc + 4.
- i_stall=1 for 2 cycles at PC=8: o_imem_raddr stays 8 and the IF/ID contents are unchanged for 2 cycles. Fetch then resumes at 8 followed by 12, with nothing lost and nothing duplicated.
- i_redirect_en=1 with target 0x40 at PC=0x10: next cycle o_imem_raddr=0x40 and o_if_valid=0 (NOP). The following cycle o_if_pc=0x40.
- i_redirect_en and i_stall asserted together with target 0x80: redirect wins, giving PC=0x80 and an IF/ID bubble.
- Redirect to 0x42: o_trap_misaligned=1 and o_halted=1. PC stays put, the IF/ID bubble persists, and later redirects are ignored. i_rst clears everything back to PC=RESET_ADDR.
- i_halt=1 at PC=0x20: o_halted=1 and o_if_valid=0 thereafter, and o_imem_raddr stays 0x20. Asserting reset mid-halt returns the stage to S_BOOT at RESET_ADDR.
